// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      operation request, accepted only while busy is low
//   sub        0: a+b+carry_in, 1: a-b-carry_in (carry_in acts as borrow-in)
//   a, b       packed BCD operands, digit i at [4i+3:4i]
//   carry_in   carry-in (add) / borrow-in (sub)
//   busy       high during every digit-processing cycle
//   done       one-cycle pulse when sum/carry_out/invalid are updated
//   sum        packed BCD result modulo 10^DIGITS
//   carry_out  decimal carry (add) or borrow (sub)
//   invalid    an operand digit latched at start was above 9
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;
    logic            c_q;
    logic            inv_q;
    logic [W-1:0]    res_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            invalid_q;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      bd;
    logic [4:0]      t;
    logic [4:0]      t6;
    logic [3:0]      d;
    logic            c_d;
    logic [W-1:0]    res_d;
    logic            inv_scan;
    logic            accept;

    // Scan the operands as presented; the result is captured only on accept.
    always_comb begin
        inv_scan = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                inv_scan = 1'b1;
            end
        end
    end

    // One decimal digit step. Subtraction uses the nines' complement of b
    // with the internal carry seeded to ~borrow_in, giving a ten's-complement
    // result; the final carry is inverted to report the borrow.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        bd = sub_q ? (4'd9 - b_dig) : b_dig;
        t  = {1'b0, a_dig} + {1'b0, bd} + {4'd0, c_q};
        t6 = t + 5'd6;
        if (t > 5'd9) begin
            d   = t6[3:0];
            c_d = 1'b1;
        end else begin
            d   = t[3:0];
            c_d = 1'b0;
        end
        res_d = res_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                res_d[4*i +: 4] = d;
            end
        end
    end

    assign accept = start && (state_q != S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            c_q       <= 1'b0;
            inv_q     <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        c_q     <= sub ? ~carry_in : carry_in;
                        inv_q   <= inv_scan;
                        res_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_q <= res_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        sum_q     <= res_d;
                        cout_q    <= sub_q ? ~c_d : c_d;
                        invalid_q <= inv_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - scoreboard bench for bcd_addsub_serial (DIGITS=4 and DIGITS=1)
module tb_bcd_addsub_serial;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub, carry_in;
    logic [15:0] a, b;
    logic        busy, done, carry_out, invalid;
    logic [15:0] sum;

    logic        s1_start, s1_sub, s1_cin;
    logic [3:0]  s1_a, s1_b;
    logic        s1_busy, s1_done, s1_cout, s1_inv;
    logic [3:0]  s1_sum;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .invalid(invalid)
    );

    bcd_addsub_serial #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
        .carry_in(s1_cin), .busy(s1_busy), .done(s1_done), .sum(s1_sum),
        .carry_out(s1_cout), .invalid(s1_inv)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        inv;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   bcnt = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (done) done_seen++;
                if (sb.size() > 0 && !done && cyc > sb[0].due) begin
                    check("done_timeout", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'd1, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("latency", cyc, mon_e.due);
                        check("sum", {16'd0, sum}, {16'd0, mon_e.sum});
                        check("carry_out", {31'd0, carry_out}, {31'd0, mon_e.cout});
                        check("invalid", {31'd0, invalid}, {31'd0, mon_e.inv});
                        check("busy_cycles", bcnt, D);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    // Called just after a negedge; leaves start low after the accept edge.
    task automatic issue_op(input bit s, input logic [15:0] aa, input logic [15:0] bb,
                            input bit cin, input logic [15:0] es, input bit ec, input bit ei);
        exp_t e;
        sub = s; a = aa; b = bb; carry_in = cin; start = 1'b1;
        e.sum = es; e.cout = ec; e.inv = ei; e.due = cyc + D + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); carry_in = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic model_op(input bit s, input logic [15:0] aa, input logic [15:0] bb,
                            input bit cin, output logic [15:0] es, output bit ec);
        int r;
        ec = 1'b0;
        r = s ? bcd2int(aa) - bcd2int(bb) - int'(cin) : bcd2int(aa) + bcd2int(bb) + int'(cin);
        if (r < 0) begin r += 10000; ec = 1'b1; end
        else if (r >= 10000) begin r -= 10000; ec = 1'b1; end
        es = int2bcd(r);
    endtask

    task automatic run_op(input bit s, input logic [15:0] aa, input logic [15:0] bb, input bit cin);
        logic [15:0] es;
        bit ec;
        model_op(s, aa, bb, cin, es, ec);
        issue_op(s, aa, bb, cin, es, ec, 1'b0);
        wait_idle();
    endtask

    initial begin
        logic [15:0] es;
        logic [15:0] ra, rb;
        bit ec;
        int c0, lat, dn;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; carry_in = 1'b0; a = 16'd0; b = 16'd0;
        s1_start = 1'b0; s1_sub = 1'b0; s1_cin = 1'b0; s1_a = 4'd0; s1_b = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, carry_out}, 32'd0);
        check("rst_invalid", {31'd0, invalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'h0999, 16'h0003, 1'b0);
        run_op(1'b0, 16'h9999, 16'h0001, 1'b0);
        run_op(1'b0, 16'h0009, 16'h0000, 1'b1);
        run_op(1'b1, 16'h0100, 16'h0001, 1'b0);
        run_op(1'b1, 16'h0001, 16'h0002, 1'b0);
        run_op(1'b1, 16'h0000, 16'h0000, 1'b1);
        run_op(1'b0, 16'h9999, 16'h9999, 1'b1);

        // Non-BCD digit: 10+0 -> digit 0 with carry into digit 1.
        issue_op(1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
        wait_idle();
        model_op(1'b0, 16'h1234, 16'h4321, 1'b0, es, ec);
        issue_op(1'b0, 16'h1234, 16'h4321, 1'b0, es, ec, 1'b0);
        check("invalid_held", {31'd0, invalid}, 32'd1);
        wait_idle();

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_op(1'($urandom), ra, rb, 1'($urandom));
        end

        // start pulsed mid-run must be ignored.
        model_op(1'b0, 16'h2468, 16'h1357, 1'b0, es, ec);
        issue_op(1'b0, 16'h2468, 16'h1357, 1'b0, es, ec, 1'b0);
        @(negedge clk);
        sub = 1'b1; a = 16'h0000; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back: start raised in the done cycle.
        model_op(1'b0, 16'h0500, 16'h0500, 1'b0, es, ec);
        issue_op(1'b0, 16'h0500, 16'h0500, 1'b0, es, ec, 1'b0);
        for (int k = 0; k < 20 && !done; k++) @(negedge clk);
        check("b2b_first_done", {31'd0, done}, 32'd1);
        model_op(1'b1, 16'h0005, 16'h0007, 1'b1, es, ec);
        issue_op(1'b1, 16'h0005, 16'h0007, 1'b1, es, ec, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Reset during RUN aborts with no done and cleared results.
        sub = 1'b0; a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, carry_out}, 32'd0);
        check("abort_invalid", {31'd0, invalid}, 32'd0);
        rst_n = 1'b1;
        dn = done_seen;
        repeat (D + 3) @(negedge clk);
        check("abort_no_done", done_seen - dn, 32'd0);

        // DIGITS=1 instance: 9+9 -> 8 carry 1, two edges.
        s1_a = 4'h9; s1_b = 4'h9; s1_sub = 1'b0; s1_cin = 1'b0; s1_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        s1_start = 1'b0;
        for (int k = 0; k < 10 && !s1_done; k++) @(negedge clk);
        lat = cyc - c0;
        check("d1_done", {31'd0, s1_done}, 32'd1);
        check("d1_latency", lat, 32'd2);
        check("d1_sum", {28'd0, s1_sum}, 32'h8);
        check("d1_cout", {31'd0, s1_cout}, 32'd1);
        check("d1_invalid", {31'd0, s1_inv}, 32'd0);
        repeat (2) @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
